// File: rtl/uart_boot_loader.sv
// UART frame bootloader: assembles SYNC/LEN/ADDR/DATA/CSUM frames from the RX FIFO,
// writes the image to memory, answers ACK/NAK and holds the CPU in reset until loaded.
module uart_boot_loader #(
  parameter int          ADDR_W  = 32,
  parameter int          DATA_W  = 32,
  parameter int          LEN_W   = 16,
  parameter int          TIMEOUT = 100000,
  parameter logic [7:0]  SYNC    = 8'hA5,
  parameter logic [7:0]  ACK     = 8'h06,
  parameter logic [7:0]  NAK     = 8'h15
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              boot_skip,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              mem_wvalid,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_wready,
  output logic              cpu_rst_n,
  output logic              boot_done,
  output logic              boot_err
);

  localparam int WB    = DATA_W / 8;
  localparam int LB    = LEN_W / 8;
  localparam int AB    = ADDR_W / 8;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {START, IDLE, LEN, ADDR, DATA, WRITE, CSUM, RESP, DONE} state_t;

  state_t           state;
  logic [LEN_W-1:0] len_cnt;
  logic [7:0]       byte_cnt;
  logic [7:0]       csum;
  logic [TMR_W-1:0] timer;
  logic             resp_ok;
  logic             rx_fire;
  logic             last_byte;

  assign rx_fire = rx_valid & rx_ready;

  always_comb begin
    last_byte = 1'b0;
    case (state)
      LEN:     last_byte = (byte_cnt == 8'(LB - 1));
      ADDR:    last_byte = (byte_cnt == 8'(AB - 1));
      DATA:    last_byte = (byte_cnt == 8'(WB - 1));
      default: last_byte = 1'b0;
    endcase
  end

  // Every output is a register updated alongside the state transition that owns it,
  // so rx_ready already reflects the next state when a field completes.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state      <= START;
      len_cnt    <= '0;
      byte_cnt   <= '0;
      csum       <= '0;
      timer      <= '0;
      resp_ok    <= 1'b0;
      rx_ready   <= 1'b0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      mem_wvalid <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
      cpu_rst_n  <= 1'b0;
      boot_done  <= 1'b0;
      boot_err   <= 1'b0;
    end else begin
      case (state)
        START: begin
          if (boot_skip) begin
            state     <= DONE;
            cpu_rst_n <= 1'b1;
            boot_done <= 1'b1;
          end else begin
            state    <= IDLE;
            rx_ready <= 1'b1;
          end
        end

        IDLE: begin
          if (rx_fire && rx_data == SYNC) begin
            state    <= LEN;
            boot_err <= 1'b0;
            csum     <= '0;
            byte_cnt <= '0;
            timer    <= '0;
          end
        end

        LEN, ADDR, DATA, CSUM: begin
          if (rx_fire) begin
            timer    <= '0;
            byte_cnt <= byte_cnt + 8'd1;
            if (state != CSUM) csum <= csum + rx_data;
            case (state)
              LEN: begin
                len_cnt <= (len_cnt >> 8) | (LEN_W'(rx_data) << (LEN_W - 8));
                if (last_byte) begin
                  byte_cnt <= '0;
                  state    <= ADDR;
                end
              end
              ADDR: begin
                mem_waddr <= (mem_waddr >> 8) | (ADDR_W'(rx_data) << (ADDR_W - 8));
                if (last_byte) begin
                  byte_cnt <= '0;
                  state    <= (len_cnt != '0) ? DATA : CSUM;
                end
              end
              DATA: begin
                mem_wdata <= (mem_wdata >> 8) | (DATA_W'(rx_data) << (DATA_W - 8));
                if (last_byte) begin
                  byte_cnt   <= '0;
                  mem_wvalid <= 1'b1;
                  rx_ready   <= 1'b0;
                  state      <= WRITE;
                end
              end
              CSUM: begin
                resp_ok  <= (rx_data == csum);
                tx_data  <= (rx_data == csum) ? ACK : NAK;
                boot_err <= (rx_data != csum);
                tx_valid <= 1'b1;
                rx_ready <= 1'b0;
                state    <= RESP;
              end
              default: ;
            endcase
          end else if (timer == TMR_W'(TIMEOUT - 1)) begin
            resp_ok  <= 1'b0;
            tx_data  <= NAK;
            tx_valid <= 1'b1;
            boot_err <= 1'b1;
            rx_ready <= 1'b0;
            state    <= RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        WRITE: begin
          if (mem_wready) begin
            mem_wvalid <= 1'b0;
            mem_waddr  <= mem_waddr + ADDR_W'(WB);
            len_cnt    <= len_cnt - LEN_W'(1);
            rx_ready   <= 1'b1;
            state      <= (len_cnt == LEN_W'(1)) ? CSUM : DATA;
          end
        end

        RESP: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (resp_ok) begin
              state     <= DONE;
              cpu_rst_n <= 1'b1;
              boot_done <= 1'b1;
            end else begin
              state    <= IDLE;
              rx_ready <= 1'b1;
            end
          end
        end

        DONE: ;

        default: begin
          state    <= IDLE;
          rx_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: expected writes and response bytes are queued
// as frames are driven and popped by the memory/TX responders when the DUT emits them.
module tb_uart_boot_loader;

  typedef logic [7:0] byte_q_t[$];

  logic        clock;
  logic        rst_n;
  logic        boot_skip;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        mem_wvalid;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_wready;
  logic        cpu_rst_n;
  logic        boot_done;
  logic        boot_err;

  int checks = 0;
  int errors = 0;
  int stuck = 0;
  int stall_left = 0;
  int stall_seen = 0;
  int wr_seen = 0;

  logic [63:0] exp_wr[$];
  logic [7:0]  exp_tx[$];
  logic [63:0] prev_wr;
  logic [63:0] exp_w;
  logic [7:0]  exp_b;
  logic        have_prev = 1'b0;

  uart_boot_loader #(
    .ADDR_W(32), .DATA_W(32), .LEN_W(16), .TIMEOUT(64),
    .SYNC(8'hA5), .ACK(8'h06), .NAK(8'h15)
  ) dut (
    .clock(clock), .rst_n(rst_n), .boot_skip(boot_skip),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .mem_wvalid(mem_wvalid), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wready(mem_wready), .cpu_rst_n(cpu_rst_n), .boot_done(boot_done),
    .boot_err(boot_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Memory and TX responders: pop the scoreboard on each accepted write/response,
  // and verify address/data stay frozen while a write is stalled.
  always @(negedge clock) begin
    if (!rst_n) begin
      mem_wready = 1'b0;
      tx_ready   = 1'b0;
      have_prev  = 1'b0;
    end else begin
      if (mem_wvalid) begin
        if (have_prev) begin
          checks++;
          if ({mem_waddr, mem_wdata} !== prev_wr) begin
            errors++;
            $display("[TB] FAIL stall_stable: got %h expected %h", {mem_waddr, mem_wdata}, prev_wr);
          end
        end
        if (stall_left > 0) begin
          mem_wready = 1'b0;
          stall_left--;
          stall_seen++;
          prev_wr   = {mem_waddr, mem_wdata};
          have_prev = 1'b1;
        end else begin
          mem_wready = 1'b1;
          have_prev  = 1'b0;
          wr_seen++;
          checks++;
          if (exp_wr.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_write: got %h@%h expected none", mem_wdata, mem_waddr);
          end else begin
            exp_w = exp_wr.pop_front();
            if ({mem_waddr, mem_wdata} !== exp_w) begin
              errors++;
              $display("[TB] FAIL mem_write: got %h@%h expected %h@%h",
                       mem_wdata, mem_waddr, exp_w[31:0], exp_w[63:32]);
            end
          end
        end
      end else begin
        mem_wready = 1'b0;
        have_prev  = 1'b0;
      end

      if (tx_valid) begin
        tx_ready = 1'b1;
        checks++;
        if (exp_tx.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_tx: got %h expected none", tx_data);
        end else begin
          exp_b = exp_tx.pop_front();
          if (tx_data !== exp_b) begin
            errors++;
            $display("[TB] FAIL tx_byte: got %h expected %h", tx_data, exp_b);
          end
        end
      end else begin
        tx_ready = 1'b0;
      end
    end
  end

  task automatic do_reset(input logic skip);
    @(negedge clock);
    rst_n      = 1'b0;
    boot_skip  = skip;
    rx_valid   = 1'b0;
    stall_left = 0;
    stall_seen = 0;
    wr_seen    = 0;
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clock);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (!rx_ready) stuck++;
    else begin
      @(posedge clock);
      #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input byte_q_t f, input int first);
    for (int i = first; i < f.size(); i++) send_byte(f[i]);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      if (boot_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_nak_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      if (exp_tx.size() == 0 && !tx_valid && rx_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic applyStimulus_happy(output bit ok);
    byte_q_t f;
    f = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00,
          8'h78, 8'h56, 8'h34, 8'h12, 8'h16};
    exp_wr.push_back({32'h0000_0100, 32'h1234_5678});
    exp_tx.push_back(8'h06);
    send_frame(f, 0);
    wait_done(ok);
  endtask

  task automatic test_reset();
    rst_n     = 1'b1;
    boot_skip = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    #12;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rx_ready, tx_valid, tx_data, mem_wvalid, mem_waddr, mem_wdata,
         cpu_rst_n, boot_done, boot_err} !== 78'd0) begin
      errors++;
      $display("[TB] FAIL reset_values: got %h expected 0",
               {rx_ready, tx_valid, tx_data, mem_wvalid, mem_waddr, mem_wdata,
                cpu_rst_n, boot_done, boot_err});
    end
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if ({rx_ready, cpu_rst_n, boot_done} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL idle_after_start: got %b expected 100", {rx_ready, cpu_rst_n, boot_done});
    end
  endtask

  task automatic test_happy();
    bit ok;
    do_reset(1'b0);
    applyStimulus_happy(ok);
    checks++;
    if (!ok || stuck != 0) begin
      errors++;
      $display("[TB] FAIL happy_done: got done=%0b stuck=%0d expected done=1 stuck=0", ok, stuck);
    end
    checks++;
    if ({cpu_rst_n, boot_done, boot_err, rx_ready} !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL happy_flags: got %b expected 1100", {cpu_rst_n, boot_done, boot_err, rx_ready});
    end
    checks++;
    if (exp_wr.size() + exp_tx.size() != 0 || wr_seen != 1) begin
      errors++;
      $display("[TB] FAIL happy_drain: got pending=%0d writes=%0d expected 0 and 1",
               exp_wr.size() + exp_tx.size(), wr_seen);
    end
  endtask

  task automatic test_stall();
    bit ok;
    byte_q_t f;
    f = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
          8'h13, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h11};
    do_reset(1'b0);
    stall_left = 3;
    exp_wr.push_back({32'h0000_0000, 32'h0000_0013});
    exp_wr.push_back({32'h0000_0004, 32'hFFFF_FFFF});
    exp_tx.push_back(8'h06);
    send_frame(f, 0);
    wait_done(ok);
    checks++;
    if (!ok || stuck != 0) begin
      errors++;
      $display("[TB] FAIL stall_done: got done=%0b stuck=%0d expected done=1 stuck=0", ok, stuck);
    end
    checks++;
    if (stall_seen != 3 || wr_seen != 2) begin
      errors++;
      $display("[TB] FAIL stall_count: got stalls=%0d writes=%0d expected 3 and 2", stall_seen, wr_seen);
    end
    checks++;
    if (exp_wr.size() + exp_tx.size() != 0) begin
      errors++;
      $display("[TB] FAIL stall_drain: got pending=%0d expected 0", exp_wr.size() + exp_tx.size());
    end
  endtask

  task automatic test_bad_csum();
    bit ok;
    byte_q_t f;
    f = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00,
          8'h78, 8'h56, 8'h34, 8'h12, 8'h17};
    do_reset(1'b0);
    exp_wr.push_back({32'h0000_0100, 32'h1234_5678});
    exp_tx.push_back(8'h15);
    send_frame(f, 0);
    wait_nak_idle(ok);
    checks++;
    if (!ok || stuck != 0) begin
      errors++;
      $display("[TB] FAIL nak_idle: got ok=%0b stuck=%0d expected ok=1 stuck=0", ok, stuck);
    end
    checks++;
    if ({boot_err, cpu_rst_n, boot_done} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL nak_flags: got %b expected 100", {boot_err, cpu_rst_n, boot_done});
    end
    f[11] = 8'h16;
    exp_wr.push_back({32'h0000_0100, 32'h1234_5678});
    exp_tx.push_back(8'h06);
    send_byte(8'hA5);
    checks++;
    if (boot_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_clear_at_sync: got %b expected 0", boot_err);
    end
    send_frame(f, 1);
    wait_done(ok);
    checks++;
    if (!ok || {cpu_rst_n, boot_err} !== 2'b10 || exp_wr.size() + exp_tx.size() != 0) begin
      errors++;
      $display("[TB] FAIL resend_ack: got done=%0b rst_err=%b pending=%0d expected 1 10 0",
               ok, {cpu_rst_n, boot_err}, exp_wr.size() + exp_tx.size());
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    do_reset(1'b0);
    exp_tx.push_back(8'h15);
    send_byte(8'hA5);
    send_byte(8'h01);
    n = 0;
    while (!tx_valid && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    checks++;
    if (n != 64) begin
      errors++;
      $display("[TB] FAIL timeout_latency: got %0d cycles expected 64", n);
    end
    checks++;
    if (boot_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_err: got %b expected 1", boot_err);
    end
    wait_nak_idle(ok);
    send_byte(8'h00);
    send_byte(8'h00);
    checks++;
    if (!ok || {rx_ready, boot_err} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL junk_discard: got ok=%0b rdy_err=%b expected 1 11", ok, {rx_ready, boot_err});
    end
    applyStimulus_happy(ok);
    checks++;
    if (!ok || stuck != 0 || exp_wr.size() + exp_tx.size() != 0) begin
      errors++;
      $display("[TB] FAIL after_timeout_load: got done=%0b stuck=%0d pending=%0d expected 1 0 0",
               ok, stuck, exp_wr.size() + exp_tx.size());
    end
  endtask

  task automatic test_zero_len();
    bit ok;
    byte_q_t f;
    f = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    do_reset(1'b0);
    exp_tx.push_back(8'h06);
    send_frame(f, 0);
    wait_done(ok);
    checks++;
    if (!ok || wr_seen != 0 || exp_tx.size() != 0) begin
      errors++;
      $display("[TB] FAIL zero_len: got done=%0b writes=%0d pending=%0d expected 1 0 0",
               ok, wr_seen, exp_tx.size());
    end
  endtask

  task automatic test_skip();
    do_reset(1'b1);
    #1;
    checks++;
    if ({cpu_rst_n, boot_done} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL skip_start: got %b expected 00", {cpu_rst_n, boot_done});
    end
    @(posedge clock);
    #1;
    checks++;
    if ({cpu_rst_n, boot_done, rx_ready} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL skip_done: got %b expected 110", {cpu_rst_n, boot_done, rx_ready});
    end
    boot_skip = 1'b0;
  endtask

  task automatic test_mid_reset();
    bit ok;
    byte_q_t f;
    f = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h78, 8'h56};
    do_reset(1'b0);
    send_frame(f, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rx_ready, tx_valid, tx_data, mem_wvalid, mem_waddr, mem_wdata,
         cpu_rst_n, boot_done, boot_err} !== 78'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset_values: got %h expected 0",
               {rx_ready, tx_valid, tx_data, mem_wvalid, mem_waddr, mem_wdata,
                cpu_rst_n, boot_done, boot_err});
    end
    do_reset(1'b0);
    applyStimulus_happy(ok);
    checks++;
    if (!ok || stuck != 0 || wr_seen != 1 || exp_wr.size() + exp_tx.size() != 0) begin
      errors++;
      $display("[TB] FAIL mid_reset_reload: got done=%0b stuck=%0d writes=%0d expected 1 0 1",
               ok, stuck, wr_seen);
    end
  endtask

  initial begin
    test_reset();
    test_happy();
    test_stall();
    test_bad_csum();
    test_timeout();
    test_zero_len();
    test_skip();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
